// File: rtl/process_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// process_scheduler_pkg : shared encodings and defaults for the scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package process_scheduler_pkg;

   localparam int          DEF_PIDW    = 4;
   localparam int          DEF_NPROC   = 10;
   localparam int          DEF_QUANTUM = 8;
   localparam int          DEF_PSIZE   = 300;
   localparam logic [31:0] DEF_IDLE_PC = 32'd73;
   localparam logic [31:0] DEF_END_PC  = 32'd236;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_READY   = 2'd1,
      SLOT_BLOCKED = 2'd2,
      SLOT_RUNNING = 2'd3
   } slot_state_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_LOAD   = 3'd2,
      ST_RUN    = 3'd3,
      ST_SAVE   = 3'd4
   } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/process_scheduler_if.sv
// ---------------------------------------------------------------------------
// process_scheduler_if : CPU/menu <-> scheduler signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface process_scheduler_if
   import process_scheduler_pkg::*;
#(
   parameter int PIDW = DEF_PIDW
);
   logic            enable;
   logic            create_valid;
   logic [PIDW-1:0] create_pid;
   logic            instr_retire;
   logic [31:0]     pc_in;
   logic            io_block;
   logic            io_done;
   logic [PIDW-1:0] io_pid;
   logic            proc_exit;
   logic            switch_ack;
   logic            switch_valid;
   logic [31:0]     new_pc;
   logic [PIDW-1:0] current_pid;
   logic            idle;
   logic            all_done;

   modport master (
      output enable, create_valid, create_pid, instr_retire, pc_in,
             io_block, io_done, io_pid, proc_exit, switch_ack,
      input  switch_valid, new_pc, current_pid, idle, all_done
   );

   modport slave (
      input  enable, create_valid, create_pid, instr_retire, pc_in,
             io_block, io_done, io_pid, proc_exit, switch_ack,
      output switch_valid, new_pc, current_pid, idle, all_done
   );
endinterface

`default_nettype wire

// File: rtl/process_scheduler_quantum_timer.sv
// ---------------------------------------------------------------------------
// process_scheduler_quantum_timer : retired-instruction counter per time slice
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module process_scheduler_quantum_timer
   import process_scheduler_pkg::*;
#(
   parameter int QUANTUM = DEF_QUANTUM
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  clear,
   input  wire  retire,
   output logic expire
);
   localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   logic [CW-1:0] count_q, count_d;
   logic          at_last;

   assign at_last = (count_q == CW'(QUANTUM - 1));
   assign expire  = retire && at_last;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (retire)
         count_d = at_last ? '0 : count_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

`default_nettype wire

// File: rtl/process_scheduler.sv
// ---------------------------------------------------------------------------
// process_scheduler : round-robin process table, quantum and context switching
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module process_scheduler
   import process_scheduler_pkg::*;
#(
   parameter int          NPROC   = DEF_NPROC,
   parameter int          PIDW    = DEF_PIDW,
   parameter int          QUANTUM = DEF_QUANTUM,
   parameter int          PSIZE   = DEF_PSIZE,
   parameter logic [31:0] IDLE_PC = DEF_IDLE_PC,
   parameter logic [31:0] END_PC  = DEF_END_PC
) (
   input wire                clk,
   input wire                reset,
   process_scheduler_if.slave bus
);
   sched_state_e    state_q, state_d;
   logic [PIDW-1:0] cur_pid_q, cur_pid_d;
   logic [PIDW-1:0] sel_pid_q, sel_pid_d;
   logic [PIDW-1:0] scan_pid_q, scan_pid_d;
   logic [PIDW-1:0] scan_cnt_q, scan_cnt_d;
   logic [31:0]     new_pc_q, new_pc_d;
   logic            idle_q, idle_d;
   logic            all_done_q, all_done_d;

   slot_state_e     slot_state_q [1:NPROC];
   slot_state_e     slot_state_d [1:NPROC];
   logic [31:0]     slot_pc_q    [1:NPROC];
   logic [31:0]     slot_pc_d    [1:NPROC];

   logic            tbl_we, tbl_pc_we;
   logic [PIDW-1:0] tbl_pid;
   slot_state_e     tbl_state;
   logic            any_ready, any_blocked;
   logic            create_ok;
   logic            tmr_clear, tmr_retire, tmr_expire;

   function automatic logic [PIDW-1:0] nxt_pid(input logic [PIDW-1:0] p);
      if (p >= PIDW'(NPROC))
         return PIDW'(1);
      return p + PIDW'(1);
   endfunction

   assign create_ok  = bus.create_valid && (bus.create_pid >= PIDW'(1)) &&
                       (bus.create_pid <= PIDW'(NPROC));
   assign tmr_retire = (state_q == ST_RUN) && bus.instr_retire;
   assign tmr_clear  = (state_q == ST_LOAD) && bus.switch_ack && (sel_pid_q != '0);

   process_scheduler_quantum_timer #(
      .QUANTUM (QUANTUM)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .retire (tmr_retire),
      .expire (tmr_expire)
   );

   always_comb begin
      any_ready   = 1'b0;
      any_blocked = 1'b0;
      for (int i = 1; i <= NPROC; i++) begin
         if (slot_state_q[i] == SLOT_READY)   any_ready   = 1'b1;
         if (slot_state_q[i] == SLOT_BLOCKED) any_blocked = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_pid_d  = cur_pid_q;
      sel_pid_d  = sel_pid_q;
      scan_pid_d = scan_pid_q;
      scan_cnt_d = scan_cnt_q;
      new_pc_d   = new_pc_q;
      idle_d     = idle_q;
      all_done_d = all_done_q;
      tbl_we     = 1'b0;
      tbl_pc_we  = 1'b0;
      tbl_pid    = cur_pid_q;
      tbl_state  = SLOT_FREE;

      case (state_q)
         ST_IDLE: begin
            if (bus.enable && any_ready) begin
               state_d    = ST_SELECT;
               scan_pid_d = nxt_pid(cur_pid_q);
               scan_cnt_d = '0;
            end
         end
         ST_SELECT: begin
            if (slot_state_q[scan_pid_q] == SLOT_READY) begin
               state_d   = ST_LOAD;
               sel_pid_d = scan_pid_q;
               new_pc_d  = slot_pc_q[scan_pid_q];
               idle_d    = 1'b0;
            end else if (scan_cnt_q == PIDW'(NPROC - 1)) begin
               // A slot that became ready behind the pointer gets another lap
               if (any_ready) begin
                  scan_pid_d = nxt_pid(scan_pid_q);
                  scan_cnt_d = '0;
               end else begin
                  state_d   = ST_LOAD;
                  sel_pid_d = '0;
                  if (any_blocked) begin
                     new_pc_d = IDLE_PC;
                     idle_d   = 1'b1;
                  end else begin
                     new_pc_d   = END_PC;
                     idle_d     = 1'b0;
                     all_done_d = 1'b1;
                  end
               end
            end else begin
               scan_pid_d = nxt_pid(scan_pid_q);
               scan_cnt_d = scan_cnt_q + PIDW'(1);
            end
         end
         ST_LOAD: begin
            if (bus.switch_ack) begin
               cur_pid_d = sel_pid_q;
               if (sel_pid_q != '0) begin
                  state_d   = ST_RUN;
                  tbl_we    = 1'b1;
                  tbl_pid   = sel_pid_q;
                  tbl_state = SLOT_RUNNING;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RUN: begin
            if (bus.instr_retire) begin
               if (bus.proc_exit) begin
                  state_d   = ST_SAVE;
                  tbl_we    = 1'b1;
                  tbl_state = SLOT_FREE;
               end else if (bus.io_block) begin
                  state_d   = ST_SAVE;
                  tbl_we    = 1'b1;
                  tbl_pc_we = 1'b1;
                  tbl_state = SLOT_BLOCKED;
               end else if (tmr_expire) begin
                  state_d   = ST_SAVE;
                  tbl_we    = 1'b1;
                  tbl_pc_we = 1'b1;
                  tbl_state = SLOT_READY;
               end
            end
         end
         ST_SAVE: begin
            state_d    = ST_SELECT;
            scan_pid_d = nxt_pid(cur_pid_q);
            scan_cnt_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      if (create_ok)
         all_done_d = 1'b0;
   end

   // Later writers win: a create overrides a same-cycle io_done or FSM update
   always_comb begin
      for (int i = 1; i <= NPROC; i++) begin
         slot_state_d[i] = slot_state_q[i];
         slot_pc_d[i]    = slot_pc_q[i];
         if (tbl_we && (tbl_pid == PIDW'(i))) begin
            slot_state_d[i] = tbl_state;
            if (tbl_pc_we)
               slot_pc_d[i] = bus.pc_in + 32'd1;
         end
         if (bus.io_done && (bus.io_pid == PIDW'(i)) && (slot_state_q[i] == SLOT_BLOCKED))
            slot_state_d[i] = SLOT_READY;
         if (create_ok && (bus.create_pid == PIDW'(i))) begin
            slot_state_d[i] = SLOT_READY;
            slot_pc_d[i]    = 32'(i) * 32'(PSIZE);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_pid_q  <= '0;
         sel_pid_q  <= '0;
         scan_pid_q <= PIDW'(1);
         scan_cnt_q <= '0;
         new_pc_q   <= '0;
         idle_q     <= 1'b0;
         all_done_q <= 1'b0;
         for (int i = 1; i <= NPROC; i++) begin
            slot_state_q[i] <= SLOT_FREE;
            slot_pc_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         cur_pid_q  <= cur_pid_d;
         sel_pid_q  <= sel_pid_d;
         scan_pid_q <= scan_pid_d;
         scan_cnt_q <= scan_cnt_d;
         new_pc_q   <= new_pc_d;
         idle_q     <= idle_d;
         all_done_q <= all_done_d;
         for (int i = 1; i <= NPROC; i++) begin
            slot_state_q[i] <= slot_state_d[i];
            slot_pc_q[i]    <= slot_pc_d[i];
         end
      end
   end

   assign bus.switch_valid = (state_q == ST_LOAD);
   assign bus.new_pc       = new_pc_q;
   assign bus.current_pid  = cur_pid_q;
   assign bus.idle         = idle_q;
   assign bus.all_done     = all_done_q;

endmodule

`default_nettype wire

// File: tb/tb_process_scheduler.sv
// ---------------------------------------------------------------------------
// tb_process_scheduler : scoreboard bench for process_scheduler (QUANTUM 8 and 1)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_process_scheduler;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  pid;
      logic        idl;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, create_valid, instr_retire, io_block, io_done, proc_exit, switch_ack;
   logic [3:0]  create_pid, io_pid;
   logic [31:0] pc_in;
   logic        use1;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   process_scheduler_if #(.PIDW(4)) s0 ();
   process_scheduler_if #(.PIDW(4)) s1 ();

   assign s0.enable = enable;             assign s1.enable = enable;
   assign s0.create_valid = create_valid; assign s1.create_valid = create_valid;
   assign s0.create_pid = create_pid;     assign s1.create_pid = create_pid;
   assign s0.instr_retire = instr_retire; assign s1.instr_retire = instr_retire;
   assign s0.pc_in = pc_in;               assign s1.pc_in = pc_in;
   assign s0.io_block = io_block;         assign s1.io_block = io_block;
   assign s0.io_done = io_done;           assign s1.io_done = io_done;
   assign s0.io_pid = io_pid;             assign s1.io_pid = io_pid;
   assign s0.proc_exit = proc_exit;       assign s1.proc_exit = proc_exit;
   assign s0.switch_ack = switch_ack;     assign s1.switch_ack = switch_ack;

   process_scheduler #(.QUANTUM(8)) dut  (.clk(clk), .reset(reset), .bus(s0.slave));
   process_scheduler #(.QUANTUM(1)) dut1 (.clk(clk), .reset(reset), .bus(s1.slave));

   wire        w_valid = use1 ? s1.switch_valid : s0.switch_valid;
   wire [31:0] w_pc    = use1 ? s1.new_pc       : s0.new_pc;
   wire [3:0]  w_pid   = use1 ? s1.current_pid  : s0.current_pid;
   wire        w_idle  = use1 ? s1.idle         : s0.idle;
   wire        w_done  = use1 ? s1.all_done     : s0.all_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [3:0] pid, input logic idl, input logic done);
      exp_t e;
      e.pc = pc; e.pid = pid; e.idl = idl; e.done = done;
      sb.push_back(e);
   endtask

   // Waits for a switch request, compares with the scoreboard head, then acks
   task automatic wait_switch(input int ack_dly);
      exp_t e;
      int   t = 0;
      while (!w_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() == 0) begin
         check("sb_empty", 32'(sb.size()), 1);
      end else begin
         e = sb.pop_front();
         if (!w_valid) begin
            check("switch_timeout", {31'd0, w_valid}, 1);
         end else begin
            check("new_pc", w_pc, e.pc);
            for (int i = 0; i < ack_dly; i++) begin
               @(negedge clk);
               check("hold_valid", {31'd0, w_valid}, 1);
               check("hold_pc", w_pc, e.pc);
            end
            switch_ack = 1'b1;
            @(negedge clk);
            switch_ack = 1'b0;
            check("current_pid", {28'd0, w_pid}, {28'd0, e.pid});
            check("idle", {31'd0, w_idle}, {31'd0, e.idl});
            check("all_done", {31'd0, w_done}, {31'd0, e.done});
         end
      end
   endtask

   task automatic retire(input logic [31:0] pc, input logic blk, input logic ext);
      instr_retire = 1'b1; pc_in = pc; io_block = blk; proc_exit = ext;
      @(negedge clk);
      instr_retire = 1'b0; io_block = 1'b0; proc_exit = 1'b0;
   endtask

   task automatic create(input logic [3:0] pid);
      create_valid = 1'b1; create_pid = pid;
      @(negedge clk);
      create_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; create_valid = 1'b0; create_pid = '0;
      instr_retire = 1'b0; pc_in = '0; io_block = 1'b0; io_done = 1'b0;
      io_pid = '0; proc_exit = 1'b0; switch_ack = 1'b0; use1 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, w_valid}, 0);
      check("rst_new_pc", w_pc, 0);
      check("rst_pid", {28'd0, w_pid}, 0);
      check("rst_idle", {31'd0, w_idle}, 0);
      check("rst_all_done", {31'd0, w_done}, 0);
      reset = 1'b0;

      // Scheduler stays inert while enable is low
      create(4'd1);
      create(4'd2);
      repeat (4) @(negedge clk);
      check("inert_valid", {31'd0, w_valid}, 0);
      check("inert_pid", {28'd0, w_pid}, 0);

      enable = 1'b1;
      push(32'd300, 4'd1, 1'b0, 1'b0);
      wait_switch(0);
      for (int i = 0; i < 8; i++) retire(32'd300 + 32'(i), 1'b0, 1'b0);
      push(32'd600, 4'd2, 1'b0, 1'b0);
      wait_switch(0);
      for (int i = 0; i < 8; i++) retire(32'd600 + 32'(i), 1'b0, 1'b0);
      push(32'd308, 4'd1, 1'b0, 1'b0);
      wait_switch(0);

      // pid 1 blocks on IN; its input completes during pid 2's slice
      retire(32'd308, 1'b0, 1'b0);
      retire(32'd309, 1'b0, 1'b0);
      push(32'd608, 4'd2, 1'b0, 1'b0);
      retire(32'd310, 1'b1, 1'b0);
      wait_switch(0);
      push(32'd311, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         io_done = (i == 2); io_pid = 4'd1;
         retire(32'd608 + 32'(i), 1'b0, 1'b0);
         io_done = 1'b0;
      end
      wait_switch(0);

      push(32'd616, 4'd2, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) retire(32'd311 + 32'(i), 1'b0, 1'b0);
      wait_switch(0);

      // Exit coincides with expiry on the 8th retire: pid 2 must end up FREE
      push(32'd319, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) retire(32'd616 + 32'(i), 1'b0, i == 7);
      wait_switch(0);
      push(32'd327, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) retire(32'd319 + 32'(i), 1'b0, 1'b0);
      wait_switch(0);

      // Only a blocked process remains -> idle entry, then wake on io_done
      push(32'd73, 4'd0, 1'b1, 1'b0);
      retire(32'd327, 1'b1, 1'b0);
      wait_switch(0);
      push(32'd328, 4'd1, 1'b0, 1'b0);
      io_done = 1'b1; io_pid = 4'd1;
      @(negedge clk);
      io_done = 1'b0;
      wait_switch(5);

      push(32'd236, 4'd0, 1'b0, 1'b1);
      retire(32'd328, 1'b0, 1'b1);
      wait_switch(0);
      repeat (5) @(negedge clk);
      check("done_sticky", {31'd0, w_done}, 1);
      check("done_no_switch", {31'd0, w_valid}, 0);

      // Re-create clears all_done; reset arriving mid-LOAD clears outputs at once
      create(4'd1);
      check("create_clears_done", {31'd0, w_done}, 0);
      for (int t = 0; t < 50 && !w_valid; t++) @(negedge clk);
      check("reload_valid", {31'd0, w_valid}, 1);
      check("reload_pc", w_pc, 32'd300);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", {31'd0, w_valid}, 0);
      check("arst_new_pc", w_pc, 0);
      check("arst_pid", {28'd0, w_pid}, 0);
      check("arst_idle", {31'd0, w_idle}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // QUANTUM=1 instance: sole process reselected on every retire
      use1 = 1'b1;
      push(32'd900, 4'd3, 1'b0, 1'b0);
      create(4'd3);
      wait_switch(0);
      for (int k = 0; k < 3; k++) begin
         push(32'd901 + 32'(k), 4'd3, 1'b0, 1'b0);
         retire(32'd900 + 32'(k), 1'b0, 1'b0);
         wait_switch(0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
